xmm_write_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the 32 x 64-bit q15.48 XMM register file. Three writeback sources share the file's single write port through valid/ready handshakes:
- src 0: fixed-point ALU
- src 1: fixed-point multiplier
- src 2: load unit

The block tracks which registers have a result in flight, so the issue stage can stall on read-after-write hazards. It sits between the execution units and the register file write port. It drives the port from registers on posedge; the file commits on the following negedge of the same cycle.

---
 rtl/xmm_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_xmm_write_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/xmm_write_arbiter.sv
// xmm_write_arbiter
//   Shares the single write port of the 32 x 64-bit q15.48 XMM register file
//   between three writeback sources (0: ALU, 1: multiplier, 2: load unit)
//   with round-robin arbitration. It also keeps a scoreboard of registers
//   that have a result in flight, so the issue stage can stall on RAW hazards.
//   The write port is driven from registers. The file commits on the negedge
//   of the same cycle.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   src_valid/addr/data, src_ready   per-source valid/ready write requests
//   issue_valid/addr                 destination allocation from issue stage
//   query_addr, query_busy           three operand hazard lookups
//   rf_should_write/addr/data        registered register-file write port
//   pending                          scoreboard vector, bit 0 always 0
//   err_unexpected                   sticky: write to a non-pending register
module xmm_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  src_valid,
  input  logic [3*ADDR_WIDTH-1:0]     src_addr,
  input  logic [3*DATA_WIDTH-1:0]     src_data,
  output logic [2:0]                  src_ready,
  input  logic                        issue_valid,
  input  logic [ADDR_WIDTH-1:0]       issue_addr,
  input  logic [3*ADDR_WIDTH-1:0]     query_addr,
  output logic [2:0]                  query_busy,
  output logic                        rf_should_write,
  output logic [ADDR_WIDTH-1:0]       rf_write_addr,
  output logic [DATA_WIDTH-1:0]       rf_write_data,
  output logic [2**ADDR_WIDTH-1:0]    pending,
  output logic                        err_unexpected
);

  localparam int unsigned NumRegs = 2**ADDR_WIDTH;

  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic                  rf_should_write_q, rf_should_write_d;
  logic [ADDR_WIDTH-1:0] rf_write_addr_q, rf_write_addr_d;
  logic [DATA_WIDTH-1:0] rf_write_data_q, rf_write_data_d;
  logic [NumRegs-1:0]    pending_q, pending_d;
  logic                  err_q, err_d;

  logic [2:0]            grant;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  // Round-robin search starting at rr_ptr_q; rr_ptr_q never holds 3.
  always_comb begin
    grant = 3'b000;
    case (rr_ptr_q)
      2'd0: begin
        if      (src_valid[0]) grant = 3'b001;
        else if (src_valid[1]) grant = 3'b010;
        else if (src_valid[2]) grant = 3'b100;
      end
      2'd1: begin
        if      (src_valid[1]) grant = 3'b010;
        else if (src_valid[2]) grant = 3'b100;
        else if (src_valid[0]) grant = 3'b001;
      end
      default: begin
        if      (src_valid[2]) grant = 3'b100;
        else if (src_valid[0]) grant = 3'b001;
        else if (src_valid[1]) grant = 3'b010;
      end
    endcase
    if (reset) grant = 3'b000;
  end

  assign grant_any = |grant;
  assign src_ready = grant;

  // One-hot AND-OR mux of the winner's request.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < 3; i++) begin
      win_addr = win_addr | ({ADDR_WIDTH{grant[i]}} & src_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      win_data = win_data | ({DATA_WIDTH{grant[i]}} & src_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_comb begin
    rr_ptr_d          = rr_ptr_q;
    rf_should_write_d = 1'b0;
    rf_write_addr_d   = rf_write_addr_q;
    rf_write_data_d   = rf_write_data_q;
    pending_d         = pending_q;
    err_d             = err_q;

    if (grant[0]) rr_ptr_d = 2'd1;
    if (grant[1]) rr_ptr_d = 2'd2;
    if (grant[2]) rr_ptr_d = 2'd0;

    if (grant_any) begin
      rf_write_addr_d   = win_addr;
      rf_write_data_d   = win_data;
      rf_should_write_d = (win_addr != '0);
      if (win_addr != '0) begin
        // Checked against the pre-update scoreboard.
        if (!pending_q[win_addr]) err_d = 1'b1;
        pending_d[win_addr] = 1'b0;
      end
    end

    // Set after clear: a same-cycle issue means a new producer is in flight.
    if (issue_valid && (issue_addr != '0)) pending_d[issue_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q          <= 2'd0;
      rf_should_write_q <= 1'b0;
      rf_write_addr_q   <= '0;
      rf_write_data_q   <= '0;
      pending_q         <= '0;
      err_q             <= 1'b0;
    end else begin
      rr_ptr_q          <= rr_ptr_d;
      rf_should_write_q <= rf_should_write_d;
      rf_write_addr_q   <= rf_write_addr_d;
      rf_write_data_q   <= rf_write_data_d;
      pending_q         <= pending_d;
      err_q             <= err_d;
    end
  end

  // The second term covers the cycle where the write is presented but only
  // lands at negedge.
  always_comb begin
    query_busy = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (query_addr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
        query_busy[k] = pending_q[query_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] |
                        (rf_should_write_q &&
                         (rf_write_addr_q == query_addr[k*ADDR_WIDTH +: ADDR_WIDTH]));
      end
    end
  end

  assign rf_should_write = rf_should_write_q;
  assign rf_write_addr   = rf_write_addr_q;
  assign rf_write_data   = rf_write_data_q;
  assign pending         = pending_q;
  assign err_unexpected  = err_q;

endmodule

// File: tb/tb_xmm_write_arbiter.sv
module tb_xmm_write_arbiter;

  logic         clk;
  logic         reset;
  logic [2:0]   src_valid;
  logic [14:0]  src_addr;
  logic [191:0] src_data;
  logic [2:0]   src_ready;
  logic         issue_valid;
  logic [4:0]   issue_addr;
  logic [14:0]  query_addr;
  logic [2:0]   query_busy;
  logic         rf_should_write;
  logic [4:0]   rf_write_addr;
  logic [63:0]  rf_write_data;
  logic [31:0]  pending;
  logic         err_unexpected;

  int checks;
  int failures;

  xmm_write_arbiter #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .src_valid       (src_valid),
    .src_addr        (src_addr),
    .src_data        (src_data),
    .src_ready       (src_ready),
    .issue_valid     (issue_valid),
    .issue_addr      (issue_addr),
    .query_addr      (query_addr),
    .query_busy      (query_busy),
    .rf_should_write (rf_should_write),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .pending         (pending),
    .err_unexpected  (err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next posedge so registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] DataA = 64'h0000_1111_2222_3333;
  localparam logic [63:0] DataB = 64'h4444_5555_6666_7777;
  localparam logic [63:0] DataC = 64'h8888_9999_aaaa_bbbb;
  localparam logic [63:0] DataZ = 64'h0001_0000_0000_0000;

  logic [2:0] exp_ready [6];
  logic [4:0] exp_addr  [6];
  logic [63:0] exp_data [6];

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    src_valid   = 3'b111;
    src_addr    = '0;
    src_data    = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    query_addr  = '0;

    // Reset state, with requests present.
    #12;
    check("reset_ready", {61'd0, src_ready}, 64'd0);
    check("reset_we", {63'd0, rf_should_write}, 64'd0);
    check("reset_pending", {32'd0, pending}, 64'd0);
    check("reset_err", {63'd0, err_unexpected}, 64'd0);

    @(negedge clk);
    reset     = 1'b0;
    src_valid = 3'b000;

    // Allocate registers 1, 2, 3.
    for (int r = 1; r <= 3; r++) begin
      issue_valid = 1'b1;
      issue_addr  = 5'(r);
      tick();
    end
    issue_valid = 1'b0;
    check("issued_pending", {32'd0, pending}, 64'h0000_000e);

    // Round robin: all sources valid, addresses 1, 2, 3.
    exp_ready[0] = 3'b001; exp_ready[1] = 3'b010; exp_ready[2] = 3'b100;
    exp_ready[3] = 3'b001; exp_ready[4] = 3'b010; exp_ready[5] = 3'b100;
    exp_addr[0] = 5'd1; exp_addr[1] = 5'd2; exp_addr[2] = 5'd3;
    exp_addr[3] = 5'd1; exp_addr[4] = 5'd2; exp_addr[5] = 5'd3;
    exp_data[0] = DataA; exp_data[1] = DataB; exp_data[2] = DataC;
    exp_data[3] = DataA; exp_data[4] = DataB; exp_data[5] = DataC;
    src_addr  = {5'd3, 5'd2, 5'd1};
    src_data  = {DataC, DataB, DataA};
    src_valid = 3'b111;
    #1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("rr_ready_%0d", c), {61'd0, src_ready}, {61'd0, exp_ready[c]});
      tick();
      check($sformatf("rr_addr_%0d", c), {59'd0, rf_write_addr}, {59'd0, exp_addr[c]});
      check($sformatf("rr_data_%0d", c), rf_write_data, exp_data[c]);
      check($sformatf("rr_we_%0d", c), {63'd0, rf_should_write}, 64'd1);
      if (c == 2) begin
        check("rr_pending_clear", {32'd0, pending}, 64'd0);
        check("rr_err_before", {63'd0, err_unexpected}, 64'd0);
      end
      if (c == 3) check("rr_err_after", {63'd0, err_unexpected}, 64'd1);
    end

    // Mid-cycle reset while a write is being presented.
    #2;
    reset = 1'b1;
    #1;
    check("midrst_we", {63'd0, rf_should_write}, 64'd0);
    check("midrst_addr", {59'd0, rf_write_addr}, 64'd0);
    check("midrst_data", rf_write_data, 64'd0);
    check("midrst_err", {63'd0, err_unexpected}, 64'd0);
    check("midrst_ready", {61'd0, src_ready}, 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    src_valid = 3'b000;

    // Write to register 0 from source 1 is accepted but discarded.
    src_valid = 3'b010;
    src_addr  = {5'd0, 5'd0, 5'd0};
    src_data  = {64'd0, DataZ, 64'd0};
    #1;
    check("zero_ready", {61'd0, src_ready}, 64'b010);
    tick();
    src_valid = 3'b000;
    check("zero_we", {63'd0, rf_should_write}, 64'd0);
    check("zero_data", rf_write_data, DataZ);
    check("zero_pending", {32'd0, pending}, 64'd0);
    check("zero_err", {63'd0, err_unexpected}, 64'd0);

    // Scoreboard: issue 7, source 2 writes 7 three cycles later.
    query_addr  = {5'd0, 5'd0, 5'd7};
    issue_valid = 1'b1;
    issue_addr  = 5'd7;
    tick();
    issue_valid = 1'b0;
    check("sb_pending_set", {32'd0, pending}, 64'h0000_0080);
    check("sb_busy_1", {61'd0, query_busy}, 64'b001);
    tick();
    check("sb_busy_2", {61'd0, query_busy}, 64'b001);
    tick();
    src_valid = 3'b100;
    src_addr  = {5'd7, 5'd0, 5'd0};
    src_data  = {DataC, 64'd0, 64'd0};
    #1;
    check("sb_ready", {61'd0, src_ready}, 64'b100);
    check("sb_busy_3", {61'd0, query_busy}, 64'b001);
    tick();
    src_valid = 3'b000;
    check("sb_busy_grant", {61'd0, query_busy}, 64'b001);
    check("sb_pending_clear", {32'd0, pending}, 64'd0);
    check("sb_we", {63'd0, rf_should_write}, 64'd1);
    check("sb_addr", {59'd0, rf_write_addr}, 64'd7);
    tick();
    check("sb_busy_after", {61'd0, query_busy}, 64'd0);
    check("sb_err", {63'd0, err_unexpected}, 64'd0);

    // Same-register collision: write to pending 5 while re-issuing 5.
    query_addr  = {5'd0, 5'd5, 5'd0};
    issue_valid = 1'b1;
    issue_addr  = 5'd5;
    tick();
    src_valid = 3'b001;
    src_addr  = {5'd0, 5'd0, 5'd5};
    src_data  = {64'd0, 64'd0, DataA};
    #1;
    check("col_ready", {61'd0, src_ready}, 64'b001);
    tick();
    issue_valid = 1'b0;
    src_valid   = 3'b000;
    check("col_pending", {32'd0, pending}, 64'h0000_0020);
    check("col_err", {63'd0, err_unexpected}, 64'd0);
    check("col_busy", {61'd0, query_busy}, 64'b010);

    // Unexpected write: source 0 writes 9, which is not pending.
    src_valid = 3'b001;
    src_addr  = {5'd0, 5'd0, 5'd9};
    src_data  = {64'd0, 64'd0, DataB};
    tick();
    src_valid = 3'b000;
    check("unexp_err", {63'd0, err_unexpected}, 64'd1);
    check("unexp_pending", {32'd0, pending}, 64'h0000_0020);
    tick();
    tick();
    check("unexp_sticky", {63'd0, err_unexpected}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("unexp_reset", {63'd0, err_unexpected}, 64'd0);
    check("unexp_reset_pend", {32'd0, pending}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
